// File: rtl/sequence_recorder.sv
// sequence_recorder: records sampled randomizer values on button presses
// and replays them with timed on/off phases.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   random[2:0]     randomizer value, legal 1..4
//   btn             raw async button (debounced upstream)
//   play, clear     sync start-playback / empty-and-abort
//   value, value_valid  entry shown during playback
//   count, full     stored entries, count==DEPTH
//   busy, done      playback active, 1-cycle end pulse
//   err             sticky illegal capture / dropped press
module sequence_recorder #(
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 10_000_000,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    random,
  input  logic          btn,
  input  logic          play,
  input  logic          clear,
  output logic [2:0]    value,
  output logic          value_valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMAX =
    (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY_ON,
    PLAY_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    mem_q [DEPTH];
  logic [2:0]    mem_d [DEPTH];
  logic [2:0]    value_q, value_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          prev_q, prev_d;
  logic          press;
  logic          full_w;
  logic          illegal;

  assign s1_d    = btn;
  assign s2_d    = s1_q;
  assign prev_d  = s2_q;
  assign press   = s2_q & ~prev_q;
  assign full_w  = (count_q == CW'(DEPTH));
  assign illegal = (random == 3'd0) || (random > 3'd4);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    count_d = count_q;
    mem_d   = mem_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (press) begin
      if (state_q == IDLE && !full_w && !clear) begin
        mem_d[count_q[IW-1:0]] = random;
        count_d = count_q + CW'(1);
        if (illegal) err_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (clear) begin
      count_d = '0;
      state_d = IDLE;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (play) begin
            // count_d already includes a same-cycle capture
            if (count_d != '0) begin
              state_d = PLAY_ON;
              idx_d   = '0;
              timer_d = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        PLAY_ON: begin
          if (timer_q == HOLD_LAST) begin
            state_d = PLAY_GAP;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        PLAY_GAP: begin
          if (timer_q == GAP_LAST) begin
            timer_d = '0;
            if (CW'(idx_q) == count_q - CW'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = PLAY_ON;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // mem_d forwards an entry written in the same cycle
    valid_d = (state_d == PLAY_ON);
    value_d = valid_d ? mem_d[idx_d] : 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
      value_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      count_q <= count_d;
      mem_q   <= mem_d;
      value_q <= value_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign count       = count_q;
  assign full        = full_w;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sequence_recorder.sv
// tb_sequence_recorder: scoreboard bench for sequence_recorder
// (DEPTH=4, HOLD_CYCLES=3, GAP_CYCLES=2).
module tb_sequence_recorder;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
  localparam int GAP   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic [2:0]    random = 3'd1;
  logic          btn    = 1'b0;
  logic          play   = 1'b0;
  logic          clear  = 1'b0;
  logic [2:0]    value;
  logic          value_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          busy;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sequence_recorder #(
    .DEPTH(DEPTH),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .random(random),
    .btn(btn),
    .play(play),
    .clear(clear),
    .value(value),
    .value_valid(value_valid),
    .count(count),
    .full(full),
    .busy(busy),
    .done(done),
    .err(err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic d,
                                     input logic b,
                                     input logic v,
                                     input logic [2:0] val);
    return {26'd0, d, b, v, val};
  endfunction

  function automatic logic [31:0] obs();
    return pk(done, busy, value_valid, value);
  endfunction

  function automatic logic [2:0] other(input logic [2:0] r);
    return (r >= 3'd4) ? 3'd1 : r + 3'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [2:0] e);
    repeat (HOLD) exp_q.push_back(pk(1'b0, 1'b1, 1'b1, e));
    repeat (GAP) exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 3'd0));
  endtask

  task automatic push_end();
    exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 3'd0));
  endtask

  task automatic check_now(input string tag);
    chk(tag, obs(), exp_q.pop_front());
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      step();
      play = 1'b0;
      check_now(tag);
    end
  endtask

  // random holds r only on the edge where the press is captured
  task automatic press_begin(input logic [2:0] r,
                             input logic with_clear,
                             input logic with_play);
    btn = 1'b1;
    random = other(r);
    step();
    random = other(r);
    step();
    random = r;
    clear  = with_clear;
    play   = with_play;
    step();
    random = other(r);
    clear  = 1'b0;
    play   = 1'b0;
  endtask

  task automatic press_end();
    btn = 1'b0;
    repeat (3) step();
  endtask

  task automatic press_btn(input logic [2:0] r);
    press_begin(r, 1'b0, 1'b0);
    press_end();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk(tag, 32'({value, value_valid, count, full, busy, done, err}),
        32'd0);
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset("reset");

    for (int i = 1; i <= 4; i++) begin
      press_btn(3'(i));
      chk("cnt_fill", 32'(count), 32'(i));
      chk("full_fill", 32'(full), 32'(i == 4));
    end
    chk("err_fill", 32'(err), 32'd0);
    press_btn(3'd2);
    chk("err_full", 32'(err), 32'd1);
    chk("cnt_full", 32'(count), 32'd4);

    play = 1'b1;
    for (int i = 1; i <= 4; i++) push_entry(3'(i));
    push_end();
    drain("play4");
    chk("cnt_after4", 32'(count), 32'd4);

    play = 1'b1;
    step();
    play = 1'b0;
    repeat (3) step();
    chk("busy_mid", 32'(busy), 32'd1);
    do_reset("rst_mid");
    chk("busy_post", 32'(busy), 32'd0);

    press_btn(3'd3);
    press_btn(3'd1);
    chk("cnt31", 32'(count), 32'd2);
    play = 1'b1;
    push_entry(3'd3);
    push_entry(3'd1);
    push_end();
    drain("play31");

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("cnt_clr", 32'(count), 32'd0);
    play = 1'b1;
    step();
    play = 1'b0;
    chk("done_empty", 32'({done, value_valid, busy}), 32'b100);
    step();
    chk("done_empty2", 32'({done, value_valid, busy}), 32'b000);

    press_btn(3'd2);
    press_btn(3'd4);
    play = 1'b1;
    step();
    play = 1'b0;
    chk("on1", 32'({value_valid, value}), 32'({1'b1, 3'd2}));
    repeat (5) step();
    chk("on2", 32'({value_valid, value}), 32'({1'b1, 3'd4}));
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("abort",
        32'({busy, value_valid, value, count, done}), 32'd0);
    step();
    chk("abort2", 32'({busy, done}), 32'd0);
    chk("err_clean", 32'(err), 32'd0);

    press_btn(3'd3);
    play = 1'b1;
    step();
    play = 1'b0;
    press_btn(3'd2);
    chk("cnt_busy", 32'(count), 32'd1);
    chk("err_busy", 32'(err), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("err_sticky", 32'(err), 32'd1);
    do_reset("rst_err");

    press_btn(3'd1);
    chk("cnt_pc", 32'(count), 32'd1);
    press_begin(3'd2, 1'b1, 1'b0);
    press_end();
    chk("cnt_pclr", 32'(count), 32'd0);
    chk("err_pclr", 32'(err), 32'd1);
    do_reset("rst_pclr");

    press_btn(3'd0);
    chk("cnt_zero", 32'(count), 32'd1);
    chk("err_zero", 32'(err), 32'd1);
    play = 1'b1;
    push_entry(3'd0);
    push_end();
    drain("play0");
    do_reset("rst_zero");

    press_begin(3'd2, 1'b0, 1'b1);
    push_entry(3'd2);
    push_end();
    check_now("pressplay");
    btn = 1'b0;
    drain("pressplay");
    chk("cnt_pp", 32'(count), 32'd1);
    chk("err_pp", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
